fetch_issue_buffer: RTL

Dual-issue instruction queue between the fetch stage and the decode/register-read stage that feeds decode_to_execute_register.
- Accepts up to two fetched instructions per cycle.
- Presents the two oldest entries as decode slots 1 and 2.
- Pairs them only when they are safe to issue together; otherwise slot 2 is held back.
- Decouples fetch from decode stalls and is cleared on branch or jump redirect.

---
 rtl/fetch_issue_buffer.sv | 83 ++++++++
 1 files changed

// File: rtl/fetch_issue_buffer.sv
// fetch_issue_buffer: dual-issue instruction queue between fetch and decode with pair-hazard gating
// Ports: clk/rst_n (async active-low); flush clears the queue; StallD blocks pops;
// ValidF1/ValidF2, InstrF1/InstrF2, PCF1/PCF2 are the fetch pair (slot 2 younger); ReadyF
// means two free entries; ValidD*/InstrD*/PCD* are the two oldest entries; Count is occupancy.
module fetch_issue_buffer #(
  parameter int DEPTH = 8,
  parameter logic [31:0] NOP = 32'h00000013
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic StallD,
  input  logic ValidF1,
  input  logic ValidF2,
  input  logic [31:0] InstrF1,
  input  logic [31:0] InstrF2,
  input  logic [31:0] PCF1,
  input  logic [31:0] PCF2,
  output logic ReadyF,
  output logic ValidD1,
  output logic ValidD2,
  output logic [31:0] InstrD1,
  output logic [31:0] InstrD2,
  output logic [31:0] PCD1,
  output logic [31:0] PCD2,
  output logic [$clog2(DEPTH):0] Count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [AW-1:0] head, tail, hb;
  logic [31:0] a, b;
  logic w1, w2, a_wr_rd, raw, mem, ctl;
  logic [1:0] pushes, pops;
  assign hb = head + 1'b1;
  assign a = instr_q[head];
  assign b = instr_q[hb];
  // Credit only the registered occupancy so ReadyF never depends on decode stall timing.
  assign ReadyF = Count <= CW'(DEPTH - 2);
  assign w1 = ReadyF && !flush && ValidF1;
  assign w2 = ReadyF && !flush && ValidF2;
  assign pushes = {1'b0, w1} + {1'b0, w2};
  // Register-source match is checked on both rs fields whatever B's format, so it may over-split.
  assign a_wr_rd = a[6:0] != 7'b0100011 && a[6:0] != 7'b1100011 && a[11:7] != 5'd0;
  assign raw = a_wr_rd && (a[11:7] == b[19:15] || a[11:7] == b[24:20]);
  assign mem = (a[6:0] == 7'b0000011 || a[6:0] == 7'b0100011) && (b[6:0] == 7'b0000011 || b[6:0] == 7'b0100011);
  assign ctl = a[6:0] == 7'b1100011 || a[6:0] == 7'b1101111 || a[6:0] == 7'b1100111;
  always_comb begin
    ValidD1 = Count != '0;
    ValidD2 = Count >= CW'(2) && !(raw || mem || ctl);
    InstrD1 = ValidD1 ? a : NOP;
    InstrD2 = ValidD2 ? b : NOP;
    PCD1 = ValidD1 ? pc_q[head] : 32'd0;
    PCD2 = ValidD2 ? pc_q[hb] : 32'd0;
    pops = (StallD || flush) ? 2'd0 : {1'b0, ValidD1} + {1'b0, ValidD2};
  end
  always_ff @(posedge clk) begin
    if (w1) begin
      instr_q[tail] <= InstrF1;
      pc_q[tail] <= PCF1;
    end
    if (w2) begin
      instr_q[tail + AW'(w1)] <= InstrF2;
      pc_q[tail + AW'(w1)] <= PCF2;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      Count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      Count <= '0;
    end else begin
      head <= head + AW'(pops);
      tail <= tail + AW'(pushes);
      Count <= Count + CW'(pushes) - CW'(pops);
    end
  end
endmodule
